mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one synchronous single-port RAM between a CPU port and a DMA/debug port.
// Define MEM_ARB_FIXED_PRIORITY_EN to give port 0 absolute priority instead of round-robin.
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [ADDR_W:0]   addr0,
    input  logic [ADDR_W:0]   addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b01;

    logic [1:0]        state_q, state_d;
    logic              port_q, port_d;
    logic              write_q, write_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic req0, req1, grant1;
    logic unmapped;
    logic done;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic last_q, last_d;
`endif

    always_comb begin
        req0 = (cmd0 == CMD_READ) || (cmd0 == CMD_WRITE);
        req1 = (cmd1 == CMD_READ) || (cmd1 == CMD_WRITE);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        grant1 = req1 && !req0;
`else
        // Under contention the port that did not win last time gets the grant.
        grant1 = req1 && (!req0 || !last_q);
`endif
    end

    assign unmapped = addr_q[ADDR_W];

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    port_d  = grant1;
                    write_d = grant1 ? (cmd1 == CMD_WRITE) : (cmd0 == CMD_WRITE);
                    addr_d  = grant1 ? addr1 : addr0;
                    wdata_d = grant1 ? wdata1 : wdata0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    last_d  = grant1;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Writes and unmapped accesses finish here; only RAM reads wait for ram_dout.
                if (write_q || unmapped) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            port_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs are decoded from registered state so they drop to zero the moment reset asserts.
    always_comb begin
        ram_addr  = '0;
        ram_write = 1'b0;
        ram_din   = '0;
        rdata     = '0;
        done      = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (!unmapped) begin
                    ram_addr = addr_q[ADDR_W-1:0];
                    if (write_q) begin
                        ram_write = 1'b1;
                        ram_din   = wdata_q;
                    end
                end
                done = write_q || unmapped;
            end
            ST_RDATA: begin
                rdata = ram_dout;
                done  = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
        ack0 = done && !port_q;
        ack1 = done && port_q;
        busy = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM attached.
module tb_mem_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] READ  = 2'b10;
    localparam logic [1:0] WRITE = 2'b01;

    logic              clk;
    logic              reset;
    logic [1:0]        cmd0, cmd1;
    logic [ADDR_W:0]   addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_write;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int vectors;
    int miscompares;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .ram_addr(ram_addr), .ram_write(ram_write),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Invariants that must hold on every cycle regardless of the directed step.
    always @(negedge clk) begin
        vectors++;
        assert (!(ack0 && ack1)) else begin
            miscompares++;
            $error("FAIL both_acks: observed ack0=%0b ack1=%0b expected not both high", ack0, ack1);
        end
        vectors++;
        assert ((ack0 || ack1) || rdata === '0) else begin
            miscompares++;
            $error("FAIL rdata_idle: observed %0h expected 0", rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] c0, input logic [ADDR_W:0] a0, input logic [DATA_W-1:0] d0,
                                  input logic [1:0] c1, input logic [ADDR_W:0] a1, input logic [DATA_W-1:0] d1);
        cmd0 = c0; addr0 = a0; wdata0 = d0;
        cmd1 = c1; addr1 = a1; wdata1 = d1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        apply_stimulus(NOP, 9'h000, 16'h0000, NOP, 9'h000, 16'h0000);

        // Reset state
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_ack0", 32'(ack0), 32'd0);
        check_output("rst_ack1", 32'(ack1), 32'd0);
        check_output("rst_ram_write", 32'(ram_write), 32'd0);
        check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_output("rst_ram_din", 32'(ram_din), 32'd0);
        check_output("rst_rdata", 32'(rdata), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Port-0 write then read of RAM address 0x005
        $display("[TB] port 0 write/read 0x005");
        apply_stimulus(WRITE, 9'h005, 16'hABCD, NOP, 9'h000, 16'h0000);
        tick();
        check_output("wr_ack0", 32'(ack0), 32'd1);
        check_output("wr_ram_write", 32'(ram_write), 32'd1);
        check_output("wr_ram_addr", 32'(ram_addr), 32'h05);
        check_output("wr_ram_din", 32'(ram_din), 32'hABCD);
        check_output("wr_busy", 32'(busy), 32'd1);
        apply_stimulus(NOP, 9'h000, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();
        check_output("wr_idle_ack0", 32'(ack0), 32'd0);
        check_output("wr_idle_busy", 32'(busy), 32'd0);
        check_output("wr_idle_ram_write", 32'(ram_write), 32'd0);
        apply_stimulus(READ, 9'h005, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();
        check_output("rd_issue_ack0", 32'(ack0), 32'd0);
        check_output("rd_issue_ram_write", 32'(ram_write), 32'd0);
        check_output("rd_issue_ram_addr", 32'(ram_addr), 32'h05);
        tick();
        check_output("rd_ack0", 32'(ack0), 32'd1);
        check_output("rd_rdata", 32'(rdata), 32'hABCD);
        apply_stimulus(NOP, 9'h000, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();
        check_output("rd_done_ack0", 32'(ack0), 32'd0);
        check_output("rd_done_busy", 32'(busy), 32'd0);

        // Continuous contention from a fresh reset
        $display("[TB] both ports reading continuously");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        apply_stimulus(READ, 9'h005, 16'h0000, READ, 9'h005, 16'h0000);
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            automatic logic exp_port = 1'b0;
`else
            automatic logic exp_port = g[0];
`endif
            tick();
            check_output("rr_issue_ack0", 32'(ack0), 32'd0);
            check_output("rr_issue_ack1", 32'(ack1), 32'd0);
            tick();
            check_output("rr_ack0", 32'(ack0), 32'(!exp_port));
            check_output("rr_ack1", 32'(ack1), 32'(exp_port));
            check_output("rr_rdata", 32'(rdata), 32'hABCD);
            tick();
            check_output("rr_idle_busy", 32'(busy), 32'd0);
        end

        // Unmapped write and read from port 1
        $display("[TB] port 1 unmapped access 0x1FF");
        apply_stimulus(NOP, 9'h000, 16'h0000, WRITE, 9'h1FF, 16'h1234);
        tick();
        check_output("um_wr_ack1", 32'(ack1), 32'd1);
        check_output("um_wr_ram_write", 32'(ram_write), 32'd0);
        apply_stimulus(NOP, 9'h000, 16'h0000, READ, 9'h1FF, 16'h0000);
        tick();
        check_output("um_idle_ack1", 32'(ack1), 32'd0);
        tick();
        check_output("um_rd_ack1", 32'(ack1), 32'd1);
        check_output("um_rd_rdata", 32'(rdata), 32'h0000);
        check_output("um_rd_ram_write", 32'(ram_write), 32'd0);
        apply_stimulus(NOP, 9'h000, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();

        // Reset during RDATA aborts the read; the re-issued read then completes
        $display("[TB] reset during read data phase");
        apply_stimulus(READ, 9'h005, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("abort_ack0", 32'(ack0), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_rdata", 32'(rdata), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check_output("reissue_busy", 32'(busy), 32'd1);
        check_output("reissue_issue_ack0", 32'(ack0), 32'd0);
        tick();
        check_output("reissue_ack0", 32'(ack0), 32'd1);
        check_output("reissue_rdata", 32'(rdata), 32'hABCD);
        apply_stimulus(NOP, 9'h000, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();

        // Port 0 keeps holding a write after its ack while port 1 starts a read
        $display("[TB] held write versus new read");
        apply_stimulus(WRITE, 9'h010, 16'h0001, NOP, 9'h000, 16'h0000);
        tick();
        check_output("hold_wr_ack0", 32'(ack0), 32'd1);
        check_output("hold_wr_ram_addr", 32'(ram_addr), 32'h10);
        apply_stimulus(WRITE, 9'h010, 16'h0001, READ, 9'h005, 16'h0000);
        tick();
        tick();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        check_output("fp_second_ack0", 32'(ack0), 32'd1);
        check_output("fp_second_ram_write", 32'(ram_write), 32'd1);
        apply_stimulus(NOP, 9'h000, 16'h0000, READ, 9'h005, 16'h0000);
        tick();
        tick();
        check_output("fp_p1_issue_ack1", 32'(ack1), 32'd0);
        tick();
        check_output("fp_p1_ack1", 32'(ack1), 32'd1);
        check_output("fp_p1_rdata", 32'(rdata), 32'hABCD);
`else
        check_output("rr_p1_issue_ram_write", 32'(ram_write), 32'd0);
        check_output("rr_p1_issue_ram_addr", 32'(ram_addr), 32'h05);
        check_output("rr_p1_issue_ack0", 32'(ack0), 32'd0);
        tick();
        check_output("rr_p1_ack1", 32'(ack1), 32'd1);
        check_output("rr_p1_ack0", 32'(ack0), 32'd0);
        check_output("rr_p1_rdata", 32'(rdata), 32'hABCD);
        apply_stimulus(WRITE, 9'h010, 16'h0001, NOP, 9'h000, 16'h0000);
        tick();
        tick();
        check_output("rr_p0_ack0", 32'(ack0), 32'd1);
        check_output("rr_p0_ram_write", 32'(ram_write), 32'd1);
        check_output("rr_p0_ram_addr", 32'(ram_addr), 32'h10);
        check_output("rr_p0_ram_din", 32'(ram_din), 32'h0001);
`endif
        apply_stimulus(NOP, 9'h000, 16'h0000, NOP, 9'h000, 16'h0000);
        tick();
        check_output("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
